// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared constants and FSM state type for the oscillator frequency counter
package osc_pkg;

    // Default widths of the latched edge counts and of the gate-length input
    localparam int CNT_W_DEFAULT  = 16;
    localparam int GATE_W_DEFAULT = 16;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2
    } osc_state_e;

endpackage

// File: rtl/osc_edge_sync.sv
// rtl/osc_edge_sync.sv - 2-flop synchroniser plus registered rising-edge detect for one oscillator input
module osc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic osc_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;

    // Two metastability flops, then compare against the previous synchronised sample;
    // the detect flop makes the total input-to-pulse latency three clk cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= osc_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/osc_freq_counter.sv
// rtl/osc_freq_counter.sv - gated two-channel oscillator edge counter; OSC_FREQ_DIFF_EN enables the difference output
module osc_freq_counter
    import osc_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int GATE_W = GATE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              osc_a,
    input  logic              osc_b,
    output logic              busy,
    output logic              valid,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b,
    output logic              ovf_a,
    output logic              ovf_b,
    output logic [CNT_W:0]    diff
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

    osc_state_e        state_q;
    logic [GATE_W-1:0] remain_q;
    logic [GATE_W-1:0] gate_load;

    logic [CNT_W-1:0]  work_a_q, work_a_d;
    logic [CNT_W-1:0]  work_b_q, work_b_d;
    logic              wovf_a_q, wovf_a_d;
    logic              wovf_b_q, wovf_b_d;
    logic [CNT_W:0]    diff_d;

    logic              busy_q;
    logic              valid_q;
    logic [CNT_W-1:0]  count_a_q;
    logic [CNT_W-1:0]  count_b_q;
    logic              ovf_a_q;
    logic              ovf_b_q;
    logic [CNT_W:0]    diff_q;

    logic              rise_a;
    logic              rise_b;

    osc_edge_sync u_sync_a (
        .clk    (clk),
        .rst    (rst),
        .osc_i  (osc_a),
        .rise_o (rise_a)
    );

    osc_edge_sync u_sync_b (
        .clk    (clk),
        .rst    (rst),
        .osc_i  (osc_b),
        .rise_o (rise_b)
    );

    // A zero gate length still yields a single-cycle window
    assign gate_load = (gate_len == '0) ? GATE_ONE : gate_len;

    // Saturating working counters: count only inside the gate window, flag an edge lost at full scale
    always_comb begin
        work_a_d = work_a_q;
        work_b_d = work_b_q;
        wovf_a_d = wovf_a_q;
        wovf_b_d = wovf_b_q;
        if (state_q == ST_GATE) begin
            if (rise_a) begin
                if (work_a_q == CNT_MAX) begin
                    wovf_a_d = 1'b1;
                end else begin
                    work_a_d = work_a_q + 1'b1;
                end
            end
            if (rise_b) begin
                if (work_b_q == CNT_MAX) begin
                    wovf_b_d = 1'b1;
                end else begin
                    work_b_d = work_b_q + 1'b1;
                end
            end
        end
    end

`ifdef OSC_FREQ_DIFF_EN
    // Signed difference of the final window counts, both zero-extended by one bit
    assign diff_d = {1'b0, work_a_d} - {1'b0, work_b_d};
`else
    assign diff_d = '0;
`endif

    // Measurement sequencer; results are captured from the next-state counts so the last
    // gate cycle is included and valid/outputs are visible during the LATCH cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            remain_q  <= '0;
            work_a_q  <= '0;
            work_b_q  <= '0;
            wovf_a_q  <= 1'b0;
            wovf_b_q  <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            count_a_q <= '0;
            count_b_q <= '0;
            ovf_a_q   <= 1'b0;
            ovf_b_q   <= 1'b0;
            diff_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_GATE;
                        remain_q <= gate_load;
                        work_a_q <= '0;
                        work_b_q <= '0;
                        wovf_a_q <= 1'b0;
                        wovf_b_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_GATE: begin
                    work_a_q <= work_a_d;
                    work_b_q <= work_b_d;
                    wovf_a_q <= wovf_a_d;
                    wovf_b_q <= wovf_b_d;
                    if (remain_q <= GATE_ONE) begin
                        state_q   <= ST_LATCH;
                        count_a_q <= work_a_d;
                        count_b_q <= work_b_d;
                        ovf_a_q   <= wovf_a_d;
                        ovf_b_q   <= wovf_b_d;
                        diff_q    <= diff_d;
                        valid_q   <= 1'b1;
                    end else begin
                        remain_q <= remain_q - 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (continuous) begin
                        state_q  <= ST_GATE;
                        remain_q <= gate_load;
                        work_a_q <= '0;
                        work_b_q <= '0;
                        wovf_a_q <= 1'b0;
                        wovf_b_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign count_a = count_a_q;
    assign count_b = count_b_q;
    assign ovf_a   = ovf_a_q;
    assign ovf_b   = ovf_b_q;
    assign diff    = diff_q;

endmodule

// File: tb/tb_osc_freq_counter.sv
// tb/tb_osc_freq_counter.sv - directed self-checking bench for osc_freq_counter
module tb_osc_freq_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        continuous;
    logic [15:0] gate_len;
    logic        osc_a = 1'b0;
    logic        osc_b = 1'b0;
    logic        osc_en = 1'b0;
    int          pa = 0;
    int          pb = 0;

    logic        busy, valid, ovf_a, ovf_b;
    logic [15:0] count_a, count_b;
    logic [16:0] diff;

    logic        busy1, valid1, ovf_a1, ovf_b1;
    logic [3:0]  count_a1, count_b1;
    logic [4:0]  diff1;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc;
    bit          found;
    int          extra;
    logic [16:0] exp_diff;

    osc_freq_counter u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .gate_len   (gate_len),
        .osc_a      (osc_a),
        .osc_b      (osc_b),
        .busy       (busy),
        .valid      (valid),
        .count_a    (count_a),
        .count_b    (count_b),
        .ovf_a      (ovf_a),
        .ovf_b      (ovf_b),
        .diff       (diff)
    );

    osc_freq_counter #(.CNT_W(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .gate_len   (gate_len),
        .osc_a      (osc_b),
        .osc_b      (osc_a),
        .busy       (busy1),
        .valid      (valid1),
        .count_a    (count_a1),
        .count_b    (count_b1),
        .ovf_a      (ovf_a1),
        .ovf_b      (ovf_b1),
        .diff       (diff1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (osc_en) begin
            pa    <= (pa + 1) % 5;
            pb    <= (pb + 1) % 4;
            osc_a <= (pa < 2);
            osc_b <= (pb < 2);
        end else begin
            osc_a <= 1'b0;
            osc_b <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_valid(input int limit, output int cycles, output bit hit);
        cycles = 0;
        hit = 1'b0;
        while (cycles < limit && !hit) begin
            tick();
            cycles++;
            if (valid) hit = 1'b1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        gate_len = 16'd0;
`ifdef OSC_FREQ_DIFF_EN
        exp_diff = 17'h1FFFB;
`else
        exp_diff = 17'h0;
`endif
        tick(); tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_count_a", count_a, 0);
        check("rst_count_b", count_b, 0);
        check("rst_diff", diff, 0);
        rst = 1'b0;

        // Basic window: 100 cycles, A period 5, B period 4
        osc_en = 1'b1;
        repeat (20) tick();
        gate_len = 16'd100;
        pulse_start();
        check("t1_busy", busy, 1);
        wait_valid(200, cyc, found);
        check("t1_found", found, 1);
        check("t1_latency", cyc, 100);
        check("t1_count_a", count_a, 20);
        check("t1_count_b", count_b, 25);
        check("t1_ovf_a", ovf_a, 0);
        check("t1_diff", diff, exp_diff);
        check("t1_sat_count", count_a1, 15);
        check("t1_sat_ovf", ovf_a1, 1);
        tick();
        check("t1_valid_drop", valid, 0);
        check("t1_idle", busy, 0);
        check("t1_hold_a", count_a, 20);

        // Continuous: three windows 11 cycles apart
        continuous = 1'b1;
        gate_len = 16'd10;
        pulse_start();
        wait_valid(50, cyc, found);
        check("t2_latency", cyc, 10);
        check("t2_count_a", count_a, 2);
        wait_valid(50, cyc, found);
        check("t2_gap1", cyc, 11);
        wait_valid(50, cyc, found);
        check("t2_gap2", cyc, 11);
        continuous = 1'b0;
        tick();
        check("t2_stop", busy, 0);

        // Start and gate_len changes during GATE are ignored
        gate_len = 16'd20;
        pulse_start();
        repeat (4) tick();
        gate_len = 16'd3;
        pulse_start();
        wait_valid(100, cyc, found);
        check("t3_latency", cyc + 5, 20);
        extra = 0;
        repeat (40) begin
            tick();
            if (valid) extra++;
        end
        check("t3_extra_valid", extra, 0);
        check("t3_idle", busy, 0);
        check("t3_count_a", count_a, 4);

        // Reset in the fifth GATE cycle aborts the measurement
        gate_len = 16'd50;
        pulse_start();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_valid", valid, 0);
        check("t4_count_a", count_a, 0);
        check("t4_count_b", count_b, 0);
        check("t4_diff", diff, 0);
        extra = 0;
        repeat (60) begin
            tick();
            if (valid) extra++;
        end
        check("t4_no_valid", extra, 0);

        // Zero gate length gives a single GATE cycle
        osc_en = 1'b0;
        repeat (10) tick();
        gate_len = 16'd0;
        pulse_start();
        check("t5_gate_busy", busy, 1);
        check("t5_gate_valid", valid, 0);
        tick();
        check("t5_latch_valid", valid, 1);
        check("t5_latch_busy", busy, 1);
        check("t5_count_a", count_a, 0);
        tick();
        check("t5_end_valid", valid, 0);
        check("t5_end_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/osc_freq_counter.md
OSC_FREQ_COUNTER -- requirements
Module: osc_freq_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each edge count.
REQ-002 SHALL have parameter GATE_W, default 16, width of the gate-length input.
REQ-003 SHALL have ports: clk  input  1  single clock; all logic runs on its rising edge.
REQ-004 SHALL have ports: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports: start  input  1  one-cycle request to start a measurement.
REQ-006 SHALL have ports: continuous  input  1  when 1, measurements repeat back-to-back.
REQ-007 SHALL have ports: gate_len  input  GATE_W  gate window length in clk cycles.
REQ-008 SHALL have ports: osc_a  input  1  asynchronous digitised oscillator A (20 MHz path, after divider).
REQ-009 SHALL have ports: osc_b  input  1  asynchronous digitised oscillator B (21 MHz path, after divider).
REQ-010 SHALL have ports: busy  output  1  high in GATE or LATCH.
REQ-011 SHALL have ports: valid  output  1  one-cycle pulse when the results update.
REQ-012 SHALL have ports: count_a  output  CNT_W  latched rising-edge count of osc_a.
REQ-013 SHALL have ports: count_b  output  CNT_W  latched rising-edge count of osc_b.
REQ-014 SHALL have ports: ovf_a  output  1  count_a saturated in the last window.
REQ-015 SHALL have ports: ovf_b  output  1  count_b saturated in the last window.
REQ-016 SHALL have ports: diff  output  CNT_W+1  signed value count_a minus count_b.

Function
REQ-017 SHALL pass each osc input through a 2-flop synchroniser, then a rising-edge detector (3-cycle input latency); the inputs are specified for frequency at most clk/4.
REQ-018 SHALL implement the FSM IDLE, GATE, LATCH:
- IDLE->GATE on start.
- GATE->LATCH after exactly N GATE cycles, where N = gate_len sampled at start; gate_len=0 is treated as N=1.
- LATCH->GATE if continuous=1, reloading N from the current gate_len.
- LATCH->IDLE otherwise.
REQ-019 SHALL clear both working counters on entry to GATE and increment them only on detected edges during GATE cycles, including the last GATE cycle.
REQ-020 SHALL not count edges occurring in IDLE or LATCH, giving a one-cycle dead time between continuous windows.
REQ-021 SHALL saturate a working counter at 2^CNT_W-1 and set the matching overflow flag; the counter SHALL not wrap.
REQ-022 SHALL, in the LATCH cycle, register count_a, count_b, ovf_a, ovf_b and diff, and assert valid for that one cycle only.
REQ-023 SHALL hold all outputs between LATCH cycles.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL ignore changes to gate_len during GATE.
REQ-026 SHALL compute diff as the zero-extended count_a minus the zero-extended count_b in CNT_W+1 bits, two's complement.

Reset
REQ-027 SHALL, on rst=1 at a clk edge, force IDLE and clear all outputs (busy, valid, counts, ovf, diff), working counters and synchroniser flops to 0.
REQ-028 SHALL abort any measurement in progress when rst is asserted mid-GATE, without producing a valid pulse.

Configuration
REQ-029 SHALL use macro OSC_FREQ_DIFF_EN to control the difference output:
- Defined: diff is computed as in REQ-026.
- Undefined: diff is tied to 0 and no subtractor is synthesised.

Structure
REQ-030 SHALL place the FSM state enum and the default CNT_W/GATE_W constants in the shared package osc_pkg.
REQ-031 SHALL use one sub-module, osc_edge_sync (2-flop synchroniser plus rising-edge detect), instantiated once per oscillator input.

Verification
REQ-032 SHALL cover: osc_a period 5 clk, osc_b period 4 clk, gate_len=100, start -> valid once; count_a=20, count_b=25, diff=-5 (with OSC_FREQ_DIFF_EN).
REQ-033 SHALL cover: CNT_W=4, osc_a period 4, gate_len=100 -> count_a=15, ovf_a=1.
REQ-034 SHALL cover: continuous=1, gate_len=10, 3 windows -> valid pulses exactly 11 cycles apart.
REQ-035 SHALL cover: start pulsed again during GATE -> no restart; exactly one valid pulse.
REQ-036 SHALL cover: rst asserted at GATE cycle 5 -> next cycle busy=0 and all outputs 0; no valid pulse.
REQ-037 SHALL cover: gate_len=0, start -> exactly one GATE cycle, then valid.
